// File: rtl/fir_stream_pkg.sv
// Shared types and helpers for the FIR stream driver: FSM state encoding and
// the width helper for the FIFO occupancy count.
package fir_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_SEND        = 2'd1,
      ST_WAIT_RESULT = 2'd2,
      ST_ACK         = 2'd3
   } state_t;

   localparam int DEFAULT_FIFO_DEPTH = 8;

   // The count has to represent FIFO_DEPTH itself, hence the extra bit.
   function automatic int countWidth(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous sample FIFO with power-of-two depth; pointers wrap naturally
// and the head entry is visible combinationally for a same-edge pop.
module fir_sample_fifo
   import fir_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_push,
   input  logic [DATA_WIDTH-1:0]             iv_data,
   input  logic                              i_pop,
   output logic [DATA_WIDTH-1:0]             ov_head,
   output logic [countWidth(FIFO_DEPTH)-1:0] ov_count,
   output logic                              o_full,
   output logic                              o_empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = countWidth(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wrPtr;
   logic [AW-1:0]         r_rdPtr;
   logic [CW-1:0]         r_count;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_badDepth
      $error("fir_sample_fifo: FIFO_DEPTH must be a power of two and at least 2");
   end

   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[r_wrPtr] <= iv_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wrPtr <= r_wrPtr + 1'b1;
         if (i_pop)  r_rdPtr <= r_rdPtr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign ov_head  = r_mem[r_rdPtr];
   assign ov_count = r_count;
   assign o_full   = (r_count == CW'(FIFO_DEPTH));
   assign o_empty  = (r_count == '0);

endmodule

// File: rtl/fir_stream_driver.sv
// Initiator-side driver for the FIR sample/result handshake, one transaction in flight.
// Optional watchdog enabled by defining FIR_STREAM_DRIVER_TIMEOUT_EN.
module fir_stream_driver
   import fir_stream_pkg::*;
#(
   parameter int DATA_WIDTH     = 24,
   parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_en,
   input  logic [DATA_WIDTH-1:0]             iv_s_data,
   input  logic                              i_s_valid,
   output logic                              o_s_ready,
   output logic [DATA_WIDTH-1:0]             ov_fir_din,
   output logic                              o_fir_din_valid,
   input  logic                              i_fir_ready,
   input  logic [DATA_WIDTH-1:0]             iv_fir_dout,
   input  logic                              i_fir_dout_valid,
   output logic                              o_fir_dout_ready,
   output logic [DATA_WIDTH-1:0]             ov_m_data,
   output logic                              o_m_valid,
   input  logic                              i_m_ready,
   output logic [countWidth(FIFO_DEPTH)-1:0] ov_fifo_count,
   output logic                              o_busy,
   output logic                              o_timeout
);

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_firDin;
   logic                  r_firDinValid;
   logic                  r_firDoutReady;
   logic [DATA_WIDTH-1:0] r_mData;
   logic                  r_mValid;

   logic [DATA_WIDTH-1:0] w_head;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_capture;
   logic                  w_wdExpired;

   if (TIMEOUT_CYCLES < 2) begin : g_badTimeout
      $error("fir_stream_driver: TIMEOUT_CYCLES must be at least 2");
   end

   assign o_s_ready = ~w_full;
   assign w_push    = i_s_valid & ~w_full;
   assign w_pop     = (r_state == ST_IDLE) & ~w_empty & i_en;
   // The output slot is free if empty or being drained on this very edge.
   assign w_capture = (r_state == ST_WAIT_RESULT) & i_fir_dout_valid & (~r_mValid | i_m_ready);

   fir_sample_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .iv_data (iv_s_data),
      .i_pop   (w_pop),
      .ov_head (w_head),
      .ov_count(ov_fifo_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

`ifdef FIR_STREAM_DRIVER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TW-1:0] r_wdCount;
   logic          r_timeout;

   // Expiry only counts when the FSM is not making progress on that same edge.
   assign w_wdExpired = (r_wdCount == TW'(TIMEOUT_CYCLES - 1)) &
                        (((r_state == ST_SEND) & ~i_fir_ready) |
                         ((r_state == ST_WAIT_RESULT) & ~w_capture));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wdCount <= '0;
         r_timeout <= 1'b0;
      end else if (w_pop || ((r_state == ST_SEND) && i_fir_ready)) begin
         r_wdCount <= '0;
      end else if (w_wdExpired) begin
         r_wdCount <= '0;
         r_timeout <= 1'b1;
      end else if (r_state == ST_SEND || r_state == ST_WAIT_RESULT) begin
         r_wdCount <= r_wdCount + 1'b1;
      end
   end

   assign o_timeout = r_timeout;
`else
   assign w_wdExpired = 1'b0;
   assign o_timeout   = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state        <= ST_IDLE;
         r_firDin       <= '0;
         r_firDinValid  <= 1'b0;
         r_firDoutReady <= 1'b0;
         r_mData        <= '0;
         r_mValid       <= 1'b0;
      end else begin
         r_firDoutReady <= 1'b0;
         if (r_mValid && i_m_ready) r_mValid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_firDin      <= w_head;
                  r_firDinValid <= 1'b1;
                  r_state       <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (i_fir_ready) begin
                  r_firDinValid <= 1'b0;
                  r_state       <= ST_WAIT_RESULT;
               end else if (w_wdExpired) begin
                  r_firDinValid <= 1'b0;
                  r_state       <= ST_IDLE;
               end
            end
            ST_WAIT_RESULT: begin
               if (w_capture) begin
                  r_mData        <= iv_fir_dout;
                  r_mValid       <= 1'b1;
                  r_firDoutReady <= 1'b1;
                  r_state        <= ST_ACK;
               end else if (w_wdExpired) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_ACK: begin
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ov_fir_din       = r_firDin;
   assign o_fir_din_valid  = r_firDinValid;
   assign o_fir_dout_ready = r_firDoutReady;
   assign ov_m_data        = r_mData;
   assign o_m_valid        = r_mValid;
   assign o_busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed scoreboard bench for fir_stream_driver; sample and result queues
// are filled as stimulus is driven and drained as the DUT produces output.
module tb_fir_stream_driver;
   import fir_stream_pkg::*;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_en;
   logic [23:0] iv_s_data;
   logic        i_s_valid;
   logic        o_s_ready;
   logic [23:0] ov_fir_din;
   logic        o_fir_din_valid;
   logic        i_fir_ready;
   logic [23:0] iv_fir_dout;
   logic        i_fir_dout_valid;
   logic        o_fir_dout_ready;
   logic [23:0] ov_m_data;
   logic        o_m_valid;
   logic        i_m_ready;
   logic [3:0]  ov_fifo_count;
   logic        o_busy;
   logic        o_timeout;

   int          testsRun;
   int          testsFailed;
   logic [23:0] sampleQ [$];
   logic [23:0] resultQ [$];
   logic [23:0] got;
   logic [23:0] held;

   fir_stream_driver #(
      .DATA_WIDTH(24),
      .FIFO_DEPTH(8),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_en            (i_en),
      .iv_s_data       (iv_s_data),
      .i_s_valid       (i_s_valid),
      .o_s_ready       (o_s_ready),
      .ov_fir_din      (ov_fir_din),
      .o_fir_din_valid (o_fir_din_valid),
      .i_fir_ready     (i_fir_ready),
      .iv_fir_dout     (iv_fir_dout),
      .i_fir_dout_valid(i_fir_dout_valid),
      .o_fir_dout_ready(o_fir_dout_ready),
      .ov_m_data       (ov_m_data),
      .o_m_valid       (o_m_valid),
      .i_m_ready       (i_m_ready),
      .ov_fifo_count   (ov_fifo_count),
      .o_busy          (o_busy),
      .o_timeout       (o_timeout)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [23:0] observed, input logic [23:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [23:0] data);
      iv_s_data = data;
      i_s_valid = 1'b1;
      sampleQ.push_back(data);
      tick();
      i_s_valid = 1'b0;
   endtask

   task automatic waitLaunch(output logic [23:0] sample);
      int n = 0;
      while (!o_fir_din_valid && n < 20) begin
         tick();
         n++;
      end
      checkOutput("launchValid", 24'(o_fir_din_valid), 24'd1);
      checkOutput("launchState", 24'(dut.r_state), 24'(ST_SEND));
      sample = ov_fir_din;
      checkOutput("sampleQueued", 24'(sampleQ.size() != 0), 24'd1);
      if (sampleQ.size() != 0) checkOutput("launchData", ov_fir_din, sampleQ.pop_front());
   endtask

   task automatic finishTxn(input logic [23:0] res);
      i_fir_ready = 1'b1;
      tick();
      i_fir_ready = 1'b0;
      checkOutput("waitState", 24'(dut.r_state), 24'(ST_WAIT_RESULT));
      checkOutput("dinDropped", 24'(o_fir_din_valid), 24'd0);
      iv_fir_dout      = res;
      i_fir_dout_valid = 1'b1;
      resultQ.push_back(res);
      tick();
      i_fir_dout_valid = 1'b0;
      checkOutput("ackHigh", 24'(o_fir_dout_ready), 24'd1);
      checkOutput("ackState", 24'(dut.r_state), 24'(ST_ACK));
      checkOutput("mValid", 24'(o_m_valid), 24'd1);
      checkOutput("mData", ov_m_data, resultQ.pop_front());
      i_m_ready = 1'b1;
      tick();
      i_m_ready = 1'b0;
      checkOutput("ackLow", 24'(o_fir_dout_ready), 24'd0);
      checkOutput("mDrained", 24'(o_m_valid), 24'd0);
   endtask

   task automatic doReset();
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      sampleQ.delete();
      resultQ.delete();
   endtask

   initial begin
      testsRun         = 0;
      testsFailed      = 0;
      i_rst_n          = 1'b0;
      i_en             = 1'b0;
      iv_s_data        = '0;
      i_s_valid        = 1'b0;
      i_fir_ready      = 1'b0;
      iv_fir_dout      = '0;
      i_fir_dout_valid = 1'b0;
      i_m_ready        = 1'b0;
      tick();
      doReset();
      checkOutput("rstSReady", 24'(o_s_ready), 24'd1);
      checkOutput("rstDinValid", 24'(o_fir_din_valid), 24'd0);
      checkOutput("rstMValid", 24'(o_m_valid), 24'd0);
      checkOutput("rstCount", 24'(ov_fifo_count), 24'd0);
      checkOutput("rstBusy", 24'(o_busy), 24'd0);
      checkOutput("rstTimeout", 24'(o_timeout), 24'd0);
      checkOutput("rstAck", 24'(o_fir_dout_ready), 24'd0);

      // Single sample, one-edge launch latency
      i_en = 1'b1;
      applyStimulus(24'h000123);
      checkOutput("t1Count", 24'(ov_fifo_count), 24'd1);
      checkOutput("t1NotYet", 24'(o_fir_din_valid), 24'd0);
      tick();
      checkOutput("t1Latency", 24'(o_fir_din_valid), 24'd1);
      waitLaunch(got);
      finishTxn(24'h0ABCDE);
      checkOutput("t1Idle", 24'(o_busy), 24'd0);

      // Fill the FIFO with launches disabled, then drain in order
      i_en = 1'b0;
      for (int i = 0; i < 8; i++) applyStimulus(24'hA00000 | 24'(i * 24'h1111));
      checkOutput("t2Count", 24'(ov_fifo_count), 24'd8);
      checkOutput("t2Full", 24'(o_s_ready), 24'd0);
      checkOutput("t2Idle", 24'(o_busy), 24'd0);
      iv_s_data = 24'hDEAD00;
      i_s_valid = 1'b1;
      tick();
      i_s_valid = 1'b0;
      checkOutput("t2NoOverflow", 24'(ov_fifo_count), 24'd8);
      i_en = 1'b1;
      tick();
      checkOutput("t2CountPop", 24'(ov_fifo_count), 24'd7);
      checkOutput("t2ReadyBack", 24'(o_s_ready), 24'd1);
      for (int i = 0; i < 8; i++) begin
         waitLaunch(got);
         finishTxn(got ^ 24'h5A5A5A);
      end
      checkOutput("t2Empty", 24'(ov_fifo_count), 24'd0);

      // Downstream backpressure holds the second result in WAIT_RESULT
      applyStimulus(24'h111111);
      applyStimulus(24'h222222);
      waitLaunch(got);
      i_fir_ready = 1'b1;
      tick();
      i_fir_ready = 1'b0;
      iv_fir_dout      = 24'h800001;
      i_fir_dout_valid = 1'b1;
      resultQ.push_back(24'h800001);
      tick();
      i_fir_dout_valid = 1'b0;
      checkOutput("t3FirstAck", 24'(o_fir_dout_ready), 24'd1);
      tick();
      waitLaunch(got);
      i_fir_ready = 1'b1;
      tick();
      i_fir_ready = 1'b0;
      iv_fir_dout      = 24'hFFFFFE;
      i_fir_dout_valid = 1'b1;
      resultQ.push_back(24'hFFFFFE);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("t3NoAck", 24'(o_fir_dout_ready), 24'd0);
         checkOutput("t3Stall", 24'(dut.r_state), 24'(ST_WAIT_RESULT));
         checkOutput("t3Held", ov_m_data, resultQ[0]);
      end
      checkOutput("t3FirstData", ov_m_data, resultQ.pop_front());
      i_m_ready = 1'b1;
      tick();
      i_fir_dout_valid = 1'b0;
      checkOutput("t3Ack", 24'(o_fir_dout_ready), 24'd1);
      checkOutput("t3MValid", 24'(o_m_valid), 24'd1);
      checkOutput("t3SecondData", ov_m_data, resultQ.pop_front());
      tick();
      i_m_ready = 1'b0;
      checkOutput("t3Drained", 24'(o_m_valid), 24'd0);

      // Spurious handshakes are ignored
      i_fir_ready = 1'b1;
      tick();
      i_fir_ready = 1'b0;
      checkOutput("t4IdleBusy", 24'(o_busy), 24'd0);
      checkOutput("t4IdleDin", 24'(o_fir_din_valid), 24'd0);
      applyStimulus(24'h0F0F0F);
      waitLaunch(held);
      iv_fir_dout      = 24'h123456;
      i_fir_dout_valid = 1'b1;
      tick();
      tick();
      i_fir_dout_valid = 1'b0;
      checkOutput("t4SendState", 24'(dut.r_state), 24'(ST_SEND));
      checkOutput("t4SendDin", ov_fir_din, held);
      checkOutput("t4SendValid", 24'(o_fir_din_valid), 24'd1);
      checkOutput("t4NoAck", 24'(o_fir_dout_ready), 24'd0);
      checkOutput("t4NoM", 24'(o_m_valid), 24'd0);
      finishTxn(24'h654321);

      // Reset while waiting for the result abandons everything
      applyStimulus(24'h000777);
      waitLaunch(got);
      i_fir_ready = 1'b1;
      tick();
      i_fir_ready = 1'b0;
      applyStimulus(24'h000888);
      checkOutput("t5PreState", 24'(dut.r_state), 24'(ST_WAIT_RESULT));
      checkOutput("t5PreCount", 24'(ov_fifo_count), 24'd1);
      doReset();
      checkOutput("t5Count", 24'(ov_fifo_count), 24'd0);
      checkOutput("t5MValid", 24'(o_m_valid), 24'd0);
      checkOutput("t5DinValid", 24'(o_fir_din_valid), 24'd0);
      checkOutput("t5State", 24'(dut.r_state), 24'(ST_IDLE));
      applyStimulus(24'h000999);
      waitLaunch(got);
      finishTxn(24'h0C0C0C);

`ifdef FIR_STREAM_DRIVER_TIMEOUT_EN
      // Watchdog fires after 16 SEND cycles and the next sample launches
      applyStimulus(24'h00AAAA);
      applyStimulus(24'h00BBBB);
      waitLaunch(got);
      for (int i = 0; i < 15; i++) tick();
      checkOutput("t6NotYet", 24'(o_timeout), 24'd0);
      checkOutput("t6StillSend", 24'(dut.r_state), 24'(ST_SEND));
      tick();
      checkOutput("t6Timeout", 24'(o_timeout), 24'd1);
      checkOutput("t6Idle", 24'(dut.r_state), 24'(ST_IDLE));
      checkOutput("t6DinDrop", 24'(o_fir_din_valid), 24'd0);
      checkOutput("t6NoAck", 24'(o_fir_dout_ready), 24'd0);
      waitLaunch(got);
      finishTxn(24'h0DDDDD);
      checkOutput("t6Sticky", 24'(o_timeout), 24'd1);
`else
      // Without the watchdog a stalled SEND waits indefinitely
      applyStimulus(24'h00AAAA);
      waitLaunch(got);
      for (int i = 0; i < 40; i++) tick();
      checkOutput("t6Wait", 24'(dut.r_state), 24'(ST_SEND));
      checkOutput("t6WaitValid", 24'(o_fir_din_valid), 24'd1);
      checkOutput("t6NoTimeout", 24'(o_timeout), 24'd0);
      finishTxn(24'h0DDDDD);
`endif
      doReset();
      checkOutput("finalTimeout", 24'(o_timeout), 24'd0);
      checkOutput("finalBusy", 24'(o_busy), 24'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/fir_stream_driver.md
Name: fir_stream_driver

Overview:
- Initiator-side endpoint for the FIR filter's sample/result handshake.
- Buffers upstream samples in a small FIFO and presents one sample at a time to the FIR (din/valid, waits for ready pulse).
- Waits for the filtered result, acknowledges it, and hands it downstream on a valid/ready register stage.
- Sits between the sample source (ADC/DMA stream) and any fir_filter_* instance; exactly one transaction in flight.

Parameters:
- DATA_WIDTH, 24, sample/result width (two's complement).
- FIFO_DEPTH, 8, sample FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous, active-low reset.
- i_en  in  1  launch enable; gates only IDLE->SEND.
- iv_s_data  in  DATA_WIDTH  upstream sample.
- i_s_valid  in  1  upstream valid.
- o_s_ready  out  1  upstream ready; equals FIFO not full.
- ov_fir_din  out  DATA_WIDTH  sample to FIR.
- o_fir_din_valid  out  1  sample valid to FIR.
- i_fir_ready  in  1  FIR sample-consumed pulse.
- iv_fir_dout  in  DATA_WIDTH  FIR result.
- i_fir_dout_valid  in  1  FIR result valid (level).
- o_fir_dout_ready  out  1  one-cycle result acknowledge to FIR.
- ov_m_data  out  DATA_WIDTH  downstream result.
- o_m_valid  out  1  downstream valid.
- i_m_ready  in  1  downstream ready.
- ov_fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- o_busy  out  1  state != IDLE.
- o_timeout  out  1  sticky watchdog flag; constant 0 when the optional feature is out.

Behaviour:
- Reset (i_rst_n=0 at an edge): state IDLE, FIFO empty, all outputs 0, o_s_ready=1 on the following cycle. Reset mid-transaction abandons the sample and result; nothing is replayed.
- FIFO push: i_s_valid & o_s_ready at an edge. o_s_ready = (count < FIFO_DEPTH); no full-bypass. Push into a full FIFO is impossible by construction.
- Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop leaves the count unchanged.
- States: IDLE, SEND, WAIT_RESULT, ACK. Encoding is in the package.
- IDLE: if count>0 & i_en, then at the edge pop the FIFO head into ov_fir_din, set o_fir_din_valid=1, go to SEND. Latency: sample accepted at edge N into an empty FIFO gives o_fir_din_valid=1 after edge N+1.
- SEND: hold ov_fir_din and o_fir_din_valid. When i_fir_ready=1 at an edge, clear o_fir_din_valid and go to WAIT_RESULT.
- WAIT_RESULT: capture when i_fir_dout_valid=1 and the output slot is free (o_m_valid=0, or o_m_valid & i_m_ready in the same cycle). On capture:
  - load ov_m_data = iv_fir_dout;
  - set o_m_valid=1;
  - set o_fir_dout_ready=1;
  - go to ACK.
- WAIT_RESULT with the slot occupied: stall and do not acknowledge (backpressure propagates to the FIR).
- ACK: o_fir_dout_ready is high for exactly this one cycle; next edge goes to IDLE with o_fir_dout_ready=0. The earliest next launch is the edge after that.
- i_fir_dout_valid outside WAIT_RESULT is ignored.
- i_fir_ready outside SEND is ignored.
- Downstream: o_m_valid is cleared when i_m_ready=1 at an edge, unless it is reloaded in the same cycle. ov_m_data is stable while o_m_valid=1 and not accepted.
- i_en=0: no new launch. A transaction in flight completes. Pushes still accepted.
- No arithmetic on data; data passes bit-exact.

Optional Feature:
- Macro: FIR_STREAM_DRIVER_TIMEOUT_EN.
- Defined:
  - A counter clears on entering SEND and on SEND->WAIT_RESULT, and increments each cycle in SEND or WAIT_RESULT.
  - When it reaches TIMEOUT_CYCLES-1: set o_timeout=1 (sticky until reset), clear o_fir_din_valid, drop the sample, go to IDLE; no acknowledge is issued.
- Undefined: no counter is built; o_timeout is tied to 0; SEND and WAIT_RESULT wait indefinitely.

Decomposition:
- Package fir_stream_pkg: state enum typedef, state encodings, and the helper localparam for count width (clog2(FIFO_DEPTH)+1).
- Sub-module fir_sample_fifo: synchronous FIFO with push/pop/count/full/empty, parameterised by DATA_WIDTH and FIFO_DEPTH.

Test Plan:
1. Single sample: push 24'h000123 into an empty FIFO. Required:
   - o_fir_din_valid=1 one edge later with ov_fir_din=24'h000123;
   - ready pulse gives WAIT_RESULT;
   - dout_valid with 24'h0ABCDE gives o_m_valid=1, ov_m_data=24'h0ABCDE, and one-cycle o_fir_dout_ready.
2. FIFO full: hold i_en=0 and push 8 samples. Required: count=8, o_s_ready=0. Then i_en=1: samples are delivered in order, and o_s_ready returns 1 after the first pop.
3. Downstream backpressure: i_m_ready=0 with o_m_valid=1 and a second result valid. Required: no acknowledge and the state stays WAIT_RESULT. Raising i_m_ready gives capture and acknowledge in the same cycle.
4. Spurious handshakes: i_fir_ready pulsed in IDLE and i_fir_dout_valid asserted in SEND. Required: ignored; no state change and no output change.
5. Mid-transaction reset: i_rst_n=0 during WAIT_RESULT. Required:
   - the next cycle has count=0, o_m_valid=0, o_fir_din_valid=0, state IDLE;
   - a subsequent sample runs normally.
6. With FIR_STREAM_DRIVER_TIMEOUT_EN and TIMEOUT_CYCLES=16: never pulse i_fir_ready. Required:
   - o_timeout=1 after 16 SEND cycles;
   - return to IDLE and launch of the next FIFO sample;
   - o_timeout stays 1 until reset.
